// File: rtl/cdb_arbiter_if.sv
// Bundle between the producers (ALU, LSB), the CDB arbiter and the CDB snoopers.
// Handshake: a push is taken on a rising edge when *_valid=1, rdy=1, rollback=0 and the registered *_full was 0 in that cycle.
interface cdb_arbiter_if #(
  parameter int ROB_POS_W = 4,
  parameter int DATA_W    = 32
);
  logic                 alu_valid;
  logic [ROB_POS_W-1:0] alu_rob_pos;
  logic [DATA_W-1:0]    alu_val;
  logic                 alu_jump;
  logic [DATA_W-1:0]    alu_pc;
  logic                 alu_full;

  logic                 lsb_valid;
  logic [ROB_POS_W-1:0] lsb_rob_pos;
  logic [DATA_W-1:0]    lsb_val;
  logic                 lsb_full;

  logic                 cdb_valid;
  logic                 cdb_src;
  logic [ROB_POS_W-1:0] cdb_rob_pos;
  logic [DATA_W-1:0]    cdb_val;
  logic                 cdb_jump;
  logic [DATA_W-1:0]    cdb_pc;

  logic                 err_overflow;
  logic                 dbg_rr_ptr;

  modport master (
    output alu_valid, alu_rob_pos, alu_val, alu_jump, alu_pc,
    output lsb_valid, lsb_rob_pos, lsb_val,
    input  alu_full, lsb_full,
    input  cdb_valid, cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc,
    input  err_overflow, dbg_rr_ptr
  );

  modport slave (
    input  alu_valid, alu_rob_pos, alu_val, alu_jump, alu_pc,
    input  lsb_valid, lsb_rob_pos, lsb_val,
    output alu_full, lsb_full,
    output cdb_valid, cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc,
    output err_overflow, dbg_rr_ptr
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin result-bus arbiter: one FIFO per producer, one registered CDB broadcast per cycle.
// An empty FIFO offers a same-cycle push directly (bypass) so a lone result reaches the CDB next cycle.
module cdb_arbiter #(
  parameter int DEPTH     = 4,
  parameter int ROB_POS_W = 4,
  parameter int DATA_W    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          rollback,
  cdb_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ALU_W = ROB_POS_W + 2 * DATA_W + 1;
  localparam int LSB_W = ROB_POS_W + DATA_W;

  logic [ALU_W-1:0] alu_mem [DEPTH];
  logic [LSB_W-1:0] lsb_mem [DEPTH];

  logic [PTR_W-1:0] alu_head, alu_tail, lsb_head, lsb_tail;
  logic [CNT_W-1:0] alu_cnt, lsb_cnt, alu_cnt_next, lsb_cnt_next;
  logic             alu_full_q, lsb_full_q, err_q, rr_ptr, rr_next;

  logic                 cdb_valid_q, cdb_src_q, cdb_jump_q;
  logic [ROB_POS_W-1:0] cdb_rob_pos_q;
  logic [DATA_W-1:0]    cdb_val_q, cdb_pc_q;

  logic [ALU_W-1:0] alu_push_data, alu_cand_data;
  logic [LSB_W-1:0] lsb_push_data, lsb_cand_data;
  logic alu_push, lsb_push, alu_empty, lsb_empty, alu_cand, lsb_cand;
  logic grant_alu, grant_lsb, alu_pop, lsb_pop, alu_enq, lsb_enq;

  assign alu_push_data = {bus.alu_rob_pos, bus.alu_val, bus.alu_jump, bus.alu_pc};
  assign lsb_push_data = {bus.lsb_rob_pos, bus.lsb_val};

  // Pushes against a full FIFO are dropped even if that FIFO pops this cycle.
  assign alu_push  = rdy && !rollback && bus.alu_valid && !alu_full_q;
  assign lsb_push  = rdy && !rollback && bus.lsb_valid && !lsb_full_q;
  assign alu_empty = (alu_cnt == '0);
  assign lsb_empty = (lsb_cnt == '0);
  assign alu_cand  = !alu_empty || alu_push;
  assign lsb_cand  = !lsb_empty || lsb_push;
  assign alu_cand_data = alu_empty ? alu_push_data : alu_mem[alu_head];
  assign lsb_cand_data = lsb_empty ? lsb_push_data : lsb_mem[lsb_head];

  always_comb begin
    grant_alu = 1'b0;
    grant_lsb = 1'b0;
    rr_next   = rr_ptr;
    if (alu_cand && lsb_cand) begin
      grant_alu = !rr_ptr;
      grant_lsb = rr_ptr;
      rr_next   = !rr_ptr;
    end else if (alu_cand) begin
      grant_alu = 1'b1;
      rr_next   = 1'b1;
    end else if (lsb_cand) begin
      grant_lsb = 1'b1;
      rr_next   = 1'b0;
    end
  end

  assign alu_pop = grant_alu && !alu_empty;
  assign lsb_pop = grant_lsb && !lsb_empty;
  assign alu_enq = alu_push && !(grant_alu && alu_empty);
  assign lsb_enq = lsb_push && !(grant_lsb && lsb_empty);
  assign alu_cnt_next = alu_cnt + CNT_W'(alu_enq) - CNT_W'(alu_pop);
  assign lsb_cnt_next = lsb_cnt + CNT_W'(lsb_enq) - CNT_W'(lsb_pop);

  always_ff @(posedge clk) begin
    if (alu_enq) alu_mem[alu_tail] <= alu_push_data;
    if (lsb_enq) lsb_mem[lsb_tail] <= lsb_push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_head <= '0; alu_tail <= '0; alu_cnt <= '0; alu_full_q <= 1'b0;
      lsb_head <= '0; lsb_tail <= '0; lsb_cnt <= '0; lsb_full_q <= 1'b0;
      err_q <= 1'b0; rr_ptr <= 1'b0;
      cdb_valid_q <= 1'b0; cdb_src_q <= 1'b0; cdb_rob_pos_q <= '0;
      cdb_val_q <= '0; cdb_jump_q <= 1'b0; cdb_pc_q <= '0;
    end else if (rdy) begin
      if (rollback) begin
        alu_head <= '0; alu_tail <= '0; alu_cnt <= '0; alu_full_q <= 1'b0;
        lsb_head <= '0; lsb_tail <= '0; lsb_cnt <= '0; lsb_full_q <= 1'b0;
        rr_ptr <= 1'b0;
        cdb_valid_q <= 1'b0;
      end else begin
        if (alu_enq) alu_tail <= alu_tail + PTR_W'(1);
        if (alu_pop) alu_head <= alu_head + PTR_W'(1);
        if (lsb_enq) lsb_tail <= lsb_tail + PTR_W'(1);
        if (lsb_pop) lsb_head <= lsb_head + PTR_W'(1);
        alu_cnt    <= alu_cnt_next;
        lsb_cnt    <= lsb_cnt_next;
        alu_full_q <= (alu_cnt_next == CNT_W'(DEPTH));
        lsb_full_q <= (lsb_cnt_next == CNT_W'(DEPTH));
        if ((bus.alu_valid && alu_full_q) || (bus.lsb_valid && lsb_full_q)) err_q <= 1'b1;
        rr_ptr      <= rr_next;
        cdb_valid_q <= grant_alu || grant_lsb;
        if (grant_alu) begin
          cdb_src_q <= 1'b0;
          {cdb_rob_pos_q, cdb_val_q, cdb_jump_q, cdb_pc_q} <= alu_cand_data;
        end else if (grant_lsb) begin
          cdb_src_q <= 1'b1;
          {cdb_rob_pos_q, cdb_val_q} <= lsb_cand_data;
          cdb_jump_q <= 1'b0;
          cdb_pc_q   <= '0;
        end
      end
    end
  end

  assign bus.alu_full     = alu_full_q;
  assign bus.lsb_full     = lsb_full_q;
  assign bus.err_overflow = err_q;
  assign bus.dbg_rr_ptr   = rr_ptr;
  assign bus.cdb_valid    = cdb_valid_q;
  assign bus.cdb_src      = cdb_src_q;
  assign bus.cdb_rob_pos  = cdb_rob_pos_q;
  assign bus.cdb_val      = cdb_val_q;
  assign bus.cdb_jump     = cdb_jump_q;
  assign bus.cdb_pc       = cdb_pc_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: hand-computed vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_cdb_arbiter;
  localparam int DEPTH = 4;
  localparam int RW    = 4;
  localparam int DW    = 32;
  localparam int OUT_W = 6 + RW + 2 * DW;

  typedef struct {
    logic rdy, rollback;
    logic av; logic [RW-1:0] ar; logic [DW-1:0] aval; logic aj; logic [DW-1:0] apc;
    logic lv; logic [RW-1:0] lr; logic [DW-1:0] lval;
  } in_t;

  typedef struct {
    in_t              in;
    logic [OUT_W-1:0] exp;
  } vec_t;

  logic clk, rst, rdy, rollback;
  cdb_arbiter_if #(.ROB_POS_W(RW), .DATA_W(DW)) bus ();

  cdb_arbiter #(.DEPTH(DEPTH), .ROB_POS_W(RW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: one expected queue per source plus the visible CDB/flag state
  logic [RW+2*DW:0]  alu_exp_q[$];
  logic [RW+DW-1:0]  lsb_exp_q[$];
  logic m_rr, m_valid, m_src, m_jump, m_afull, m_lfull, m_err;
  logic [RW-1:0] m_rob;
  logic [DW-1:0] m_val, m_pc;

  function automatic logic [OUT_W-1:0] mk_out(input logic v, s, input logic [RW-1:0] rob,
      input logic [DW-1:0] val, input logic j, input logic [DW-1:0] pc, input logic af, lf, e);
    return {v, s, rob, val, j, pc, af, lf, e};
  endfunction

  function automatic in_t mk_in(input logic r, rb, av, input logic [RW-1:0] ar,
      input logic [DW-1:0] aval, input logic aj, input logic [DW-1:0] apc,
      input logic lv, input logic [RW-1:0] lr, input logic [DW-1:0] lval);
    in_t t;
    t.rdy = r; t.rollback = rb;
    t.av = av; t.ar = ar; t.aval = aval; t.aj = aj; t.apc = apc;
    t.lv = lv; t.lr = lr; t.lval = lval;
    return t;
  endfunction

  function automatic logic [OUT_W-1:0] dut_out();
    return {bus.cdb_valid, bus.cdb_src, bus.cdb_rob_pos, bus.cdb_val, bus.cdb_jump,
            bus.cdb_pc, bus.alu_full, bus.lsb_full, bus.err_overflow};
  endfunction

  function automatic logic [OUT_W-1:0] model_out();
    return mk_out(m_valid, m_src, m_rob, m_val, m_jump, m_pc, m_afull, m_lfull, m_err);
  endfunction

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    alu_exp_q.delete(); lsb_exp_q.delete();
    m_rr = 0; m_valid = 0; m_src = 0; m_jump = 0; m_afull = 0; m_lfull = 0; m_err = 0;
    m_rob = '0; m_val = '0; m_pc = '0;
  endtask

  // One cycle of the arbiter's rules; a push into an empty queue followed by
  // popping the winner's front is the bypass case.
  task automatic model_step(input in_t v);
    logic has_a, has_l, win;
    if (!v.rdy) return;
    if (v.rollback) begin
      alu_exp_q.delete(); lsb_exp_q.delete();
      m_rr = 0; m_valid = 0; m_afull = 0; m_lfull = 0;
      return;
    end
    if ((v.av && m_afull) || (v.lv && m_lfull)) m_err = 1;
    if (v.av && !m_afull) alu_exp_q.push_back({v.ar, v.aval, v.aj, v.apc});
    if (v.lv && !m_lfull) lsb_exp_q.push_back({v.lr, v.lval});
    has_a = alu_exp_q.size() != 0;
    has_l = lsb_exp_q.size() != 0;
    m_valid = has_a || has_l;
    win = (has_a && has_l) ? m_rr : has_l;
    if (m_valid) begin
      if (!win) begin
        {m_rob, m_val, m_jump, m_pc} = alu_exp_q.pop_front();
        m_src = 0;
      end else begin
        {m_rob, m_val} = lsb_exp_q.pop_front();
        m_jump = 0; m_pc = '0; m_src = 1;
      end
      m_rr = !win;
    end
    m_afull = alu_exp_q.size() == DEPTH;
    m_lfull = lsb_exp_q.size() == DEPTH;
  endtask

  // driver
  task automatic apply(input in_t v);
    rdy = v.rdy; rollback = v.rollback;
    bus.alu_valid = v.av; bus.alu_rob_pos = v.ar; bus.alu_val = v.aval;
    bus.alu_jump = v.aj; bus.alu_pc = v.apc;
    bus.lsb_valid = v.lv; bus.lsb_rob_pos = v.lr; bus.lsb_val = v.lval;
  endtask

  task automatic step(input in_t v, input string name);
    @(negedge clk);
    apply(v);
    @(posedge clk);
    model_step(v);
    #1;
    check(name, dut_out(), model_out());
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  vec_t            tbl[$];
  logic [RW:0]     exp_q[$];
  logic [RW:0]     got_q[$];
  in_t             idle, v;
  logic            saw_afull;

  initial begin
    idle = mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(idle);
    rst = 1'b1;
    model_reset();
    #1;
    check("reset_state", dut_out(), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // hand-computed vectors: bypass, round-robin tie, rollback, rdy=0
    tbl.push_back('{mk_in(1,0, 1,3,32'h1234,1,32'h100, 0,0,0),      mk_out(1,0,3,32'h1234,1,32'h100,0,0,0)});
    tbl.push_back('{idle,                                           mk_out(0,0,3,32'h1234,1,32'h100,0,0,0)});
    tbl.push_back('{mk_in(1,0, 1,1,32'h11,0,32'h200, 1,9,32'h99),   mk_out(1,1,9,32'h99,0,0,0,0,0)});
    tbl.push_back('{idle,                                           mk_out(1,0,1,32'h11,0,32'h200,0,0,0)});
    tbl.push_back('{idle,                                           mk_out(0,0,1,32'h11,0,32'h200,0,0,0)});
    tbl.push_back('{mk_in(1,0, 1,2,32'h22,1,32'h300, 1,10,32'haa),  mk_out(1,1,10,32'haa,0,0,0,0,0)});
    tbl.push_back('{mk_in(1,1, 1,4,32'h44,0,32'h400, 0,0,0),        mk_out(0,1,10,32'haa,0,0,0,0,0)});
    tbl.push_back('{mk_in(1,0, 0,0,0,0,0, 1,11,32'hbb),             mk_out(1,1,11,32'hbb,0,0,0,0,0)});
    tbl.push_back('{idle,                                           mk_out(0,1,11,32'hbb,0,0,0,0,0)});
    tbl.push_back('{mk_in(0,0, 1,5,32'h55,1,32'h500, 0,0,0),        mk_out(0,1,11,32'hbb,0,0,0,0,0)});
    tbl.push_back('{idle,                                           mk_out(0,1,11,32'hbb,0,0,0,0,0)});
    foreach (tbl[i]) begin
      @(negedge clk);
      apply(tbl[i].in);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
    end

    // both producers push every cycle, ignoring full, then drain
    do_reset();
    exp_q = '{5'h00, 5'h18, 5'h01, 5'h19};
    saw_afull = 1'b0;
    for (int i = 0; i < 12; i++) begin
      v = mk_in(1, 0, 1, RW'(i), 32'hA000 + i, i[0], 32'h1000 + 4 * i, 1, RW'(8 + i), 32'hB000 + i);
      step(v, "both_push");
      if (bus.cdb_valid) got_q.push_back({bus.cdb_src, bus.cdb_rob_pos});
      if (bus.alu_full) saw_afull = 1'b1;
    end
    for (int i = 0; i < 12; i++) step(idle, "drain");
    for (int i = 0; i < 4; i++)
      check($sformatf("rr_order%0d", i), OUT_W'(got_q[i]), OUT_W'(exp_q[i]));
    check("alu_full_seen", OUT_W'(saw_afull), OUT_W'(1));
    check("err_sticky", OUT_W'(bus.err_overflow), OUT_W'(1));

    // rdy held low with results queued and cdb_valid high
    do_reset();
    for (int i = 0; i < 2; i++)
      step(mk_in(1, 0, 1, RW'(i), 32'hC0 + i, 0, 32'h40 + i, 1, RW'(4 + i), 32'hD0 + i), "rdy_fill");
    for (int i = 0; i < 3; i++)
      step(mk_in(0, 0, 1, 7, 32'hDEAD, 1, 32'hBEEF, 1, 7, 32'hF00D), "rdy_hold");
    for (int i = 0; i < 5; i++) step(idle, "rdy_drain");

    // rollback with three queued per source and a simultaneous ALU push
    do_reset();
    for (int i = 0; i < 6; i++)
      step(mk_in(1, 0, 1, RW'(i), 32'hE0 + i, 1, 32'h80 + i, 1, RW'(8 + i), 32'hF0 + i), "rb_fill");
    step(mk_in(1, 1, 1, 9, 32'h99, 1, 32'h99, 0, 0, 0), "rb_flush");
    step(mk_in(1, 0, 0, 0, 0, 0, 0, 1, 12, 32'h1212), "rb_new");
    for (int i = 0; i < 5; i++) step(idle, "rb_after");

    // asynchronous reset between edges while FIFOs hold results
    do_reset();
    for (int i = 0; i < 4; i++)
      step(mk_in(1, 0, 1, RW'(i), 32'h70 + i, 1, 32'h700 + i, 1, RW'(8 + i), 32'h80 + i), "ar_fill");
    @(negedge clk);
    apply(idle);
    #2 rst = 1'b1;
    #1;
    check("async_rst", dut_out(), '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) step(idle, "ar_after");

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v.rdy      = ($urandom_range(0, 9) != 0);
      v.rollback = ($urandom_range(0, 39) == 0);
      v.av   = !v.rollback && ($urandom_range(0, 1) == 1) && (!bus.alu_full || $urandom_range(0, 7) == 0);
      v.ar   = RW'($urandom_range(0, 15));
      v.aval = $urandom;
      v.aj   = $urandom_range(0, 1) == 1;
      v.apc  = $urandom;
      v.lv   = !v.rollback && ($urandom_range(0, 2) != 0) && (!bus.lsb_full || $urandom_range(0, 7) == 0);
      v.lr   = RW'($urandom_range(0, 15));
      v.lval = $urandom;
      step(v, "random");
    end
    for (int i = 0; i < 10; i++) step(idle, "random_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
